// File: rtl/game_pkg.sv
// Shared playfield geometry, widths and game FSM state encoding for the
// frame-rate game controllers.
package game_pkg;

   localparam int c_GAME_WIDTH  = 640;
   localparam int c_GAME_HEIGHT = 480;
   localparam int c_LIVES_W     = 3;
   localparam int c_LANE_W      = 4;
   localparam int c_FRAME_CNT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PLAY   = 3'd1,
      ST_HIT    = 3'd2,
      ST_INVULN = 3'd3,
      ST_OVER   = 3'd4
   } state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// One-cycle frame tick: fires on the first cycle after the divided counters
// reach the last active pixel, even though they hold there for several clocks.
module frame_tick_gen
   import game_pkg::*;
#(
   parameter int c_WIDTH  = c_GAME_WIDTH,
   parameter int c_HEIGHT = c_GAME_HEIGHT
) (
   input  logic       i_Clk,
   input  logic       i_Rst_n,
   input  logic [9:0] i_Col_Count_Div,
   input  logic [9:0] i_Row_Count_Div,
   output logic       o_Tick
);

   logic r_At_End;
   logic r_At_End_d;

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         r_At_End   <= 1'b0;
         r_At_End_d <= 1'b0;
      end else begin
         r_At_End   <= (i_Row_Count_Div == 10'(c_HEIGHT - 1)) &&
                       (i_Col_Count_Div == 10'(c_WIDTH - 1));
         r_At_End_d <= r_At_End;
      end
   end

   assign o_Tick = r_At_End & ~r_At_End_d;

endmodule

// File: rtl/collision_ctrl.sv
// Frog/car collision detection: accumulates per-pixel overlap over a frame,
// judges it at frame end and manages lives, invulnerability and game over.
module collision_ctrl
   import game_pkg::*;
#(
   parameter int c_NUM_CARS      = 8,
   parameter int c_START_LIVES   = 3,
   parameter int c_INVULN_FRAMES = 60
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst_n,
   input  logic                  i_Game_Active,
   input  logic [9:0]            i_Col_Count_Div,
   input  logic [9:0]            i_Row_Count_Div,
   input  logic                  i_Draw_Frog,
   input  logic [c_NUM_CARS-1:0] i_Draw_Cars,
   output logic                  o_Hit,
   output logic                  o_Frog_Reset,
   output logic [c_LANE_W-1:0]   o_Hit_Lane,
   output logic [c_LIVES_W-1:0]  o_Lives,
   output logic                  o_Invuln,
   output logic                  o_Game_Over
);

   state_t                     r_State;
   state_t                     w_Next;
   logic                       w_Tick;
   logic [c_NUM_CARS-1:0]      w_Ov;
   logic                       w_Ov_Any;
   logic [c_LANE_W-1:0]        w_Enc;
   logic                       w_Frame_Hit;
   logic                       r_Seen;
   logic [c_LANE_W-1:0]        r_Lane;
   logic [c_FRAME_CNT_W-1:0]   r_Frame_Cnt;

   frame_tick_gen u_tick (
      .i_Clk           (i_Clk),
      .i_Rst_n         (i_Rst_n),
      .i_Col_Count_Div (i_Col_Count_Div),
      .i_Row_Count_Div (i_Row_Count_Div),
      .o_Tick          (w_Tick)
   );

   assign w_Ov     = {c_NUM_CARS{i_Draw_Frog}} & i_Draw_Cars;
   assign w_Ov_Any = |w_Ov;

   // Scan high to low so the lowest overlapping car wins.
   always_comb begin
      w_Enc = '0;
      for (int i = c_NUM_CARS - 1; i >= 0; i--) begin
         if (w_Ov[i]) w_Enc = c_LANE_W'(i);
      end
   end

   // Overlap coinciding with the tick still belongs to the ending frame.
   assign w_Frame_Hit = w_Tick & (r_Seen | w_Ov_Any);

   always_comb begin
      w_Next = r_State;
      if (!i_Game_Active) begin
         w_Next = ST_IDLE;
      end else begin
         case (r_State)
            ST_IDLE:   w_Next = ST_PLAY;
            ST_PLAY:   if (w_Frame_Hit) w_Next = ST_HIT;
            ST_HIT:    w_Next = (o_Lives <= c_LIVES_W'(1)) ? ST_OVER : ST_INVULN;
            ST_INVULN: if (w_Tick && r_Frame_Cnt <= c_FRAME_CNT_W'(1)) w_Next = ST_PLAY;
            ST_OVER:   w_Next = ST_OVER;
            default:   w_Next = ST_IDLE;
         endcase
      end
   end

   // Outputs are registered from the current state, so they trail it by one clock.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         r_State      <= ST_IDLE;
         r_Seen       <= 1'b0;
         r_Lane       <= '0;
         r_Frame_Cnt  <= '0;
         o_Hit        <= 1'b0;
         o_Frog_Reset <= 1'b0;
         o_Hit_Lane   <= '0;
         o_Lives      <= c_LIVES_W'(c_START_LIVES);
         o_Invuln     <= 1'b0;
         o_Game_Over  <= 1'b0;
      end else begin
         r_State      <= w_Next;
         o_Hit        <= (r_State == ST_HIT);
         o_Frog_Reset <= (r_State == ST_HIT);
         o_Invuln     <= (r_State == ST_INVULN);
         o_Game_Over  <= (r_State == ST_OVER);

         if (r_State != ST_PLAY || w_Tick) begin
            r_Seen <= 1'b0;
            r_Lane <= '0;
         end else if (w_Ov_Any && !r_Seen) begin
            r_Seen <= 1'b1;
            r_Lane <= w_Enc;
         end

         case (r_State)
            ST_IDLE: begin
               o_Lives    <= c_LIVES_W'(c_START_LIVES);
               o_Hit_Lane <= '0;
            end
            ST_PLAY: begin
               if (w_Next == ST_HIT) o_Hit_Lane <= r_Seen ? r_Lane : w_Enc;
            end
            ST_HIT: begin
               if (o_Lives != '0) o_Lives <= o_Lives - c_LIVES_W'(1);
               r_Frame_Cnt <= c_FRAME_CNT_W'(c_INVULN_FRAMES);
            end
            ST_INVULN: begin
               if (w_Tick && r_Frame_Cnt != '0) r_Frame_Cnt <= r_Frame_Cnt - c_FRAME_CNT_W'(1);
            end
            ST_OVER: begin
               o_Lives <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_collision_ctrl.sv
// Directed bench for collision_ctrl: expected hits are queued when a hit frame
// is driven and matched against each o_Hit pulse by a negedge monitor.
module tb_collision_ctrl;

   logic       i_Clk = 1'b0;
   logic       i_Rst_n;
   logic       i_Game_Active;
   logic [9:0] i_Col_Count_Div;
   logic [9:0] i_Row_Count_Div;
   logic       i_Draw_Frog;
   logic [7:0] i_Draw_Cars;
   logic       o_Hit;
   logic       o_Frog_Reset;
   logic [3:0] o_Hit_Lane;
   logic [2:0] o_Lives;
   logic       o_Invuln;
   logic       o_Game_Over;

   typedef struct {
      int         cyc;
      logic [3:0] lane;
      logic [2:0] lives;
   } hitExp_t;

   hitExp_t sbQ[$];
   hitExp_t popped;
   int      checks = 0;
   int      failures = 0;
   int      cycleCount = 0;

   collision_ctrl #(
      .c_NUM_CARS      (8),
      .c_START_LIVES   (3),
      .c_INVULN_FRAMES (2)
   ) dut (
      .i_Clk           (i_Clk),
      .i_Rst_n         (i_Rst_n),
      .i_Game_Active   (i_Game_Active),
      .i_Col_Count_Div (i_Col_Count_Div),
      .i_Row_Count_Div (i_Row_Count_Div),
      .i_Draw_Frog     (i_Draw_Frog),
      .i_Draw_Cars     (i_Draw_Cars),
      .o_Hit           (o_Hit),
      .o_Frog_Reset    (o_Frog_Reset),
      .o_Hit_Lane      (o_Hit_Lane),
      .o_Lives         (o_Lives),
      .o_Invuln        (o_Invuln),
      .o_Game_Over     (o_Game_Over)
   );

   always #5 i_Clk = ~i_Clk;

   always @(posedge i_Clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic stepCycles(input int n);
      repeat (n) begin
         @(posedge i_Clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic frog, input logic [7:0] cars,
                                input int row, input int col, input int n);
      i_Draw_Frog     = frog;
      i_Draw_Cars     = cars;
      i_Row_Count_Div = 10'(row);
      i_Col_Count_Div = 10'(col);
      stepCycles(n);
   endtask

   // The tick lands one cycle after the end coordinates are driven; o_Hit two after that.
   task automatic expectHit(input logic [3:0] lane, input logic [2:0] lives);
      sbQ.push_back('{cycleCount + 3, lane, lives});
   endtask

   task automatic midFrame(input logic frog, input logic [7:0] cars);
      applyStimulus(frog, cars, 100, 200, 5);
      applyStimulus(1'b0, 8'h00, 100, 201, 2);
   endtask

   task automatic frameEnd(input logic tickOverlap, input logic [7:0] cars);
      applyStimulus(1'b0, 8'h00, 479, 639, 1);
      applyStimulus(tickOverlap, tickOverlap ? cars : 8'h00, 479, 639, 1);
      applyStimulus(1'b0, 8'h00, 479, 639, 2);
      applyStimulus(1'b0, 8'h00, 0, 0, 4);
   endtask

   always @(negedge i_Clk) begin
      if (o_Hit === 1'b1) begin
         checkOutput("hit_pending", 32'(sbQ.size() != 0), 32'd1);
         if (sbQ.size() != 0) begin
            popped = sbQ.pop_front();
            checkOutput("hit_cycle", 32'(cycleCount), 32'(popped.cyc));
            checkOutput("hit_lane", 32'(o_Hit_Lane), 32'(popped.lane));
            checkOutput("hit_lives", 32'(o_Lives), 32'(popped.lives));
            checkOutput("hit_frog_reset", 32'(o_Frog_Reset), 32'd1);
         end
      end
   end

   initial begin
      i_Rst_n         = 1'b0;
      i_Game_Active   = 1'b1;
      i_Draw_Frog     = 1'b0;
      i_Draw_Cars     = 8'h00;
      i_Row_Count_Div = 10'd0;
      i_Col_Count_Div = 10'd0;
      stepCycles(3);
      checkOutput("rst_lives", 32'(o_Lives), 32'd3);
      checkOutput("rst_hit", 32'(o_Hit), 32'd0);
      checkOutput("rst_game_over", 32'(o_Game_Over), 32'd0);
      checkOutput("rst_invuln", 32'(o_Invuln), 32'd0);
      checkOutput("rst_lane", 32'(o_Hit_Lane), 32'd0);
      i_Rst_n = 1'b1;
      stepCycles(2);

      midFrame(1'b1, 8'h00);
      frameEnd(1'b0, 8'h00);
      checkOutput("frog_only_lives", 32'(o_Lives), 32'd3);

      midFrame(1'b1, 8'b0010_0100);
      expectHit(4'd2, 3'd2);
      frameEnd(1'b0, 8'h00);
      checkOutput("hit1_lane", 32'(o_Hit_Lane), 32'd2);
      checkOutput("hit1_lives", 32'(o_Lives), 32'd2);
      checkOutput("hit1_invuln", 32'(o_Invuln), 32'd1);

      midFrame(1'b1, 8'b1000_0000);
      frameEnd(1'b0, 8'h00);
      checkOutput("inv_tick1_invuln", 32'(o_Invuln), 32'd1);
      midFrame(1'b1, 8'b1000_0000);
      frameEnd(1'b0, 8'h00);
      checkOutput("inv_tick2_invuln", 32'(o_Invuln), 32'd0);
      checkOutput("inv_tick2_lives", 32'(o_Lives), 32'd2);

      midFrame(1'b1, 8'b1000_0000);
      expectHit(4'd7, 3'd1);
      frameEnd(1'b0, 8'h00);
      checkOutput("hit2_lives", 32'(o_Lives), 32'd1);
      checkOutput("hit2_invuln", 32'(o_Invuln), 32'd1);

      midFrame(1'b1, 8'b0100_0000);
      frameEnd(1'b0, 8'h00);
      midFrame(1'b1, 8'b0100_0000);
      frameEnd(1'b0, 8'h00);
      midFrame(1'b0, 8'h00);
      expectHit(4'd0, 3'd0);
      frameEnd(1'b1, 8'b0001_0001);
      checkOutput("over_flag", 32'(o_Game_Over), 32'd1);
      checkOutput("over_lives", 32'(o_Lives), 32'd0);
      checkOutput("over_invuln", 32'(o_Invuln), 32'd0);
      midFrame(1'b1, 8'hFF);
      frameEnd(1'b1, 8'hFF);
      checkOutput("over_hold_flag", 32'(o_Game_Over), 32'd1);
      checkOutput("over_hold_lives", 32'(o_Lives), 32'd0);

      i_Game_Active = 1'b0;
      stepCycles(2);
      checkOutput("idle_game_over", 32'(o_Game_Over), 32'd0);
      checkOutput("idle_lives", 32'(o_Lives), 32'd3);
      checkOutput("idle_lane", 32'(o_Hit_Lane), 32'd0);
      i_Game_Active = 1'b1;
      stepCycles(2);
      midFrame(1'b1, 8'b0110_0000);
      expectHit(4'd5, 3'd2);
      frameEnd(1'b0, 8'h00);
      checkOutput("abort_pre_invuln", 32'(o_Invuln), 32'd1);
      i_Game_Active = 1'b0;
      stepCycles(2);
      checkOutput("abort_invuln", 32'(o_Invuln), 32'd0);
      checkOutput("abort_lives", 32'(o_Lives), 32'd3);
      checkOutput("abort_lane", 32'(o_Hit_Lane), 32'd0);
      i_Game_Active = 1'b1;
      stepCycles(2);

      midFrame(1'b1, 8'h00);
      frameEnd(1'b1, 8'h00);
      checkOutput("frog_only2_lives", 32'(o_Lives), 32'd3);

      midFrame(1'b1, 8'b0000_1000);
      expectHit(4'd3, 3'd2);
      frameEnd(1'b0, 8'h00);
      i_Rst_n = 1'b0;
      stepCycles(1);
      checkOutput("rst_inv_invuln", 32'(o_Invuln), 32'd0);
      checkOutput("rst_inv_lives", 32'(o_Lives), 32'd3);
      i_Rst_n = 1'b1;
      stepCycles(5);

      checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/collision_ctrl.md
Name: collision_ctrl

Overview:
- Consumer side of the car-lane draw interface: reads the per-pixel draw strobes from every car controller and the frog draw strobe, and decides when the frog has been hit.
- Accumulates pixel overlap over each frame and evaluates it at frame end.
- Drives the hit pulse, frog respawn request, lives counter, invulnerability window and game-over flag back to the top-level game FSM.
- Sits between the car/frog sprite controllers and the game state logic, in the divided-pixel clock domain (same i_Clk).

Parameters:
c_GAME_WIDTH, 640, active columns of divided pixel grid
c_GAME_HEIGHT, 480, active rows of divided pixel grid
c_NUM_CARS, 8, number of car draw strobes monitored (1..16)
c_START_LIVES, 3, lives loaded on game start (1..7)
c_INVULN_FRAMES, 60, frames of collision immunity after a hit (1..255)

Ports:
i_Clk  in  1  system clock
i_Rst_n  in  1  synchronous reset, active low
i_Game_Active  in  1  game running; low forces IDLE
i_Col_Count_Div  in  10  divided column counter
i_Row_Count_Div  in  10  divided row counter
i_Draw_Frog  in  1  frog pixel strobe (registered, same alignment as car strobes)
i_Draw_Cars  in  c_NUM_CARS  one draw strobe per car controller
o_Hit  out  1  one-cycle pulse on confirmed collision
o_Frog_Reset  out  1  one-cycle pulse: frog returns to start position
o_Hit_Lane  out  4  lowest-index car that overlapped in the hit frame
o_Lives  out  3  remaining lives
o_Invuln  out  1  high during invulnerability window
o_Game_Over  out  1  high from lives exhausted until i_Game_Active falls

Behaviour:
- Reset (i_Rst_n low at posedge):
  - state=IDLE; o_Lives=c_START_LIVES.
  - All other outputs 0; accumulator and frame counter cleared.
  - Reset has priority over everything, including mid-HIT and mid-INVULN.
- Frame tick:
  - Compare (row==c_GAME_HEIGHT-1 && col==c_GAME_WIDTH-1), registered.
  - Tick is a one-cycle pulse on the cycle after the compare first goes high.
  - The divided counters hold for several clocks; the tick fires once per frame.
- Overlap detect:
  - Per cycle, ov[i] = i_Draw_Frog & i_Draw_Cars[i].
  - In PLAY, r_Seen |= |ov, and r_Lane latches the lowest set i of the first overlapping cycle in the frame.
  - r_Seen and r_Lane are cleared on every frame tick, after evaluation, and held cleared outside PLAY.
  - If overlap and tick occur in the same cycle, that overlap counts toward the ending frame.
- FSM states: IDLE, PLAY, HIT, INVULN, OVER.
  - Any state with i_Game_Active low -> IDLE next cycle (below reset in priority).
  - IDLE: o_Lives=c_START_LIVES; go to PLAY when i_Game_Active is high.
  - PLAY: on frame tick with r_Seen (or overlap that cycle) -> HIT, with o_Hit_Lane loaded; otherwise stay.
  - HIT (exactly one cycle):
    - o_Hit=1, o_Frog_Reset=1, o_Lives decrements by 1.
    - If o_Lives was 1 -> OVER; else -> INVULN with frame counter = c_INVULN_FRAMES.
  - INVULN:
    - o_Invuln=1; overlaps ignored.
    - Counter decrements on each tick; on the tick where it reaches 0 -> PLAY.
  - OVER: o_Game_Over=1; o_Lives=0; no further hits.
- Latency: o_Hit is asserted 2 clocks after the qualifying frame tick (tick -> state register -> HIT outputs). Outputs are registered.
- o_Lives never underflows below 0.
- o_Hit_Lane holds its value until the next hit or IDLE; IDLE clears it to 0.

Decomposition:
- Shared package/include (game_pkg): c_GAME_WIDTH, c_GAME_HEIGHT, FSM state encodings, lives width.
- Sub-module: frame_tick_gen (counter compare plus edge detect), reusable by other frame-rate controllers.
- Priority encoder for the lane index stays inline.

Test Plan:
- Reset: hold i_Rst_n=0 for 3 cycles with i_Game_Active=1 -> o_Lives=3, o_Hit=0, o_Game_Over=0, state IDLE. Release -> PLAY next cycle.
- Single hit:
  - Stimulus: in PLAY, assert i_Draw_Frog and i_Draw_Cars=8'b0010_0100 for 5 cycles mid-frame.
  - Response: exactly one o_Hit and o_Frog_Reset pulse 2 clocks after the frame tick; o_Hit_Lane=2, o_Lives=2, o_Invuln=1.
- Invulnerability, with c_INVULN_FRAMES=2:
  - Stimulus: overlap on every frame after a hit.
  - Response: no o_Hit for the next 2 ticks; o_Invuln drops at the 2nd tick; next overlapping frame gives o_Hit, o_Lives=1.
- Game over: three hit frames separated by immunity -> third HIT gives o_Lives=0, o_Game_Over=1. Further overlaps give no o_Hit.
- Boundary overlap: overlap only on the cycle at row=479, col=639 coinciding with the tick -> counted; hit follows.
- Abort: drop i_Game_Active during INVULN -> IDLE next cycle, o_Invuln=0, o_Lives=3. Frog strobe without any car strobe never gives o_Hit.
